// File: rtl/sync_eop_detector.sv
// USB-style receive framer: hunts for the SYNC pattern, forwards payload bits, and validates the SE0 end-of-packet.
// Optional SYNC_ERR_CNT_EN adds a saturating 8-bit err_cnt output counting sync_err/eop_err pulses.
module sync_eop_detector #(
  parameter int SYNC_LEN       = 8,
  parameter int MIN_SYNC_ZEROS = SYNC_LEN - 1,
  parameter int EOP_SE0_BITS   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_data,
  input  logic       diff,
  input  logic       bit_en,
  output logic       syn_out,
  output logic       se0,
  output logic       pkt_active,
  output logic       data_out,
  output logic       data_valid,
  output logic       eop,
  output logic       sync_err,
  output logic       eop_err,
`ifdef SYNC_ERR_CNT_EN
  output logic [7:0] err_cnt,
`endif
  output logic [1:0] state_dbg
);

  localparam int ZW = $clog2(SYNC_LEN - 1) + 1;
  localparam int SW = $clog2(EOP_SE0_BITS) + 1;
  localparam logic [ZW-1:0] ZERO_MAX = ZW'(SYNC_LEN - 1);
  localparam logic [ZW-1:0] ZERO_MIN = ZW'(MIN_SYNC_ZEROS);
  localparam logic [SW-1:0] SE0_MAX  = SW'(EOP_SE0_BITS);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACTIVE  = 2'd1,
    EOP_SE0 = 2'd2
  } state_t;

  state_t        state;
  logic [ZW-1:0] zero_cnt;
  logic [SW-1:0] se0_cnt;

  assign state_dbg = state;

  // data_valid qualifies data_out for exactly one clk; there is no backpressure,
  // every other output is a one-clk pulse except se0 and pkt_active (levels).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= HUNT;
      zero_cnt   <= '0;
      se0_cnt    <= '0;
      syn_out    <= 1'b0;
      se0        <= 1'b0;
      pkt_active <= 1'b0;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      eop        <= 1'b0;
      sync_err   <= 1'b0;
      eop_err    <= 1'b0;
    end else begin
      se0        <= ~diff;
      syn_out    <= 1'b0;
      data_valid <= 1'b0;
      eop        <= 1'b0;
      sync_err   <= 1'b0;
      eop_err    <= 1'b0;
      if (bit_en) begin
        case (state)
          HUNT: begin
            if (!diff) begin
              zero_cnt <= '0;
            end else if (!in_data) begin
              if (zero_cnt != ZERO_MAX) zero_cnt <= zero_cnt + 1'b1;
            end else if (zero_cnt >= ZERO_MIN) begin
              syn_out    <= 1'b1;
              pkt_active <= 1'b1;
              zero_cnt   <= '0;
              state      <= ACTIVE;
            end else if (zero_cnt != '0) begin
              // A short run of zeros closed by a 1 is a broken SYNC; plain idle J is not.
              sync_err <= 1'b1;
              zero_cnt <= '0;
            end
          end
          ACTIVE: begin
            if (diff) begin
              data_out   <= in_data;
              data_valid <= 1'b1;
            end else begin
              se0_cnt <= SW'(1);
              state   <= EOP_SE0;
            end
          end
          EOP_SE0: begin
            if (!diff) begin
              if (se0_cnt != SE0_MAX) se0_cnt <= se0_cnt + 1'b1;
            end else begin
              if (se0_cnt >= SE0_MAX) eop <= 1'b1;
              else                    eop_err <= 1'b1;
              pkt_active <= 1'b0;
              se0_cnt    <= '0;
              state      <= HUNT;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef SYNC_ERR_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt <= '0;
    end else if ((sync_err || eop_err) && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_eop_detector.sv
// Bench for sync_eop_detector: a full-speed instance and a high-speed (SYNC_LEN=32, MIN_SYNC_ZEROS=11) instance,
// each with an expected-event queue consumed by its own monitor.
module tb_sync_eop_detector;

  logic clk, reset, bit_en;
  logic in_data, diff, in2, diff2;
  logic syn_out, se0, pkt_active, data_out, data_valid, eop, sync_err, eop_err;
  logic syn_2, se0_2, pa_2, dout_2, dv_2, eop_2, serr_2, eerr_2;
  logic [1:0] state_dbg, state_2;
`ifdef SYNC_ERR_CNT_EN
  logic [7:0] err_cnt, err_cnt_2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Event word: {syn_out, data_valid, data_out&data_valid, eop, sync_err, eop_err, pkt_active}
  localparam logic [6:0] EV_SYN  = 7'b1000001;
  localparam logic [6:0] EV_D1   = 7'b0110001;
  localparam logic [6:0] EV_D0   = 7'b0100001;
  localparam logic [6:0] EV_EOP  = 7'b0001000;
  localparam logic [6:0] EV_SERR = 7'b0000100;
  localparam logic [6:0] EV_EERR = 7'b0000010;

  logic [6:0] exp_q[$];
  logic [6:0] exp_q2[$];

  sync_eop_detector dut (
    .clk(clk), .reset(reset), .in_data(in_data), .diff(diff), .bit_en(bit_en),
    .syn_out(syn_out), .se0(se0), .pkt_active(pkt_active), .data_out(data_out),
    .data_valid(data_valid), .eop(eop), .sync_err(sync_err), .eop_err(eop_err),
`ifdef SYNC_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .state_dbg(state_dbg)
  );

  sync_eop_detector #(.SYNC_LEN(32), .MIN_SYNC_ZEROS(11), .EOP_SE0_BITS(2)) dut_hs (
    .clk(clk), .reset(reset), .in_data(in2), .diff(diff2), .bit_en(bit_en),
    .syn_out(syn_2), .se0(se0_2), .pkt_active(pa_2), .data_out(dout_2),
    .data_valid(dv_2), .eop(eop_2), .sync_err(serr_2), .eop_err(eerr_2),
`ifdef SYNC_ERR_CNT_EN
    .err_cnt(err_cnt_2),
`endif
    .state_dbg(state_2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitors
  always @(negedge clk) begin
    logic [6:0] ev;
    if (!reset && (syn_out || data_valid || eop || sync_err || eop_err)) begin
      ev = {syn_out, data_valid, data_out & data_valid, eop, sync_err, eop_err, pkt_active};
      if (exp_q.size() == 0) check("fs_unexpected_event", {25'd0, ev}, 32'd0);
      else check("fs_event", {25'd0, ev}, {25'd0, exp_q.pop_front()});
    end
  end

  always @(negedge clk) begin
    logic [6:0] ev;
    if (!reset && (syn_2 || dv_2 || eop_2 || serr_2 || eerr_2)) begin
      ev = {syn_2, dv_2, dout_2 & dv_2, eop_2, serr_2, eerr_2, pa_2};
      if (exp_q2.size() == 0) check("hs_unexpected_event", {25'd0, ev}, 32'd0);
      else check("hs_event", {25'd0, ev}, {25'd0, exp_q2.pop_front()});
    end
  end

  // drivers
  task automatic bit1(input logic en, input logic d, input logic df);
    bit_en = en; in_data = d; diff = df;
    @(posedge clk); #1;
    check("fs_se0", {31'd0, se0}, {31'd0, ~df});
  endtask

  task automatic bit2(input logic d, input logic df);
    bit_en = 1'b1; in2 = d; diff2 = df;
    @(posedge clk); #1;
    check("hs_se0", {31'd0, se0_2}, {31'd0, ~df});
  endtask

  task automatic zeros1(input int n);
    for (int i = 0; i < n; i++) bit1(1'b1, 1'b0, 1'b1);
  endtask

  task automatic zeros2(input int n);
    for (int i = 0; i < n; i++) bit2(1'b0, 1'b1);
  endtask

  task automatic sync1();
    zeros1(7);
    exp_q.push_back(EV_SYN);
    bit1(1'b1, 1'b1, 1'b1);
  endtask

  task automatic data1(input logic d);
    exp_q.push_back(d ? EV_D1 : EV_D0);
    bit1(1'b1, d, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outputs"}, {24'd0, syn_out, se0, pkt_active, data_out, data_valid, eop, sync_err, eop_err}, 32'd0);
    check({tag, "_state"}, {30'd0, state_dbg}, 32'd0);
`ifdef SYNC_ERR_CNT_EN
    check({tag, "_err_cnt"}, {24'd0, err_cnt}, 32'd0);
`endif
  endtask

  initial begin
    reset = 1'b1; bit_en = 1'b0; in_data = 1'b1; diff = 1'b1; in2 = 1'b1; diff2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // idle J, SYNC, payload 1011, two SE0 bits, J -> eop
    for (int i = 0; i < 3; i++) bit1(1'b1, 1'b1, 1'b1);
    sync1();
    check("fs_pkt_active_after_sync", {31'd0, pkt_active}, 32'd1);
    data1(1'b1); data1(1'b0); data1(1'b1); data1(1'b1);
    bit1(1'b1, 1'b0, 1'b0);
    bit1(1'b1, 1'b0, 1'b0);
    exp_q.push_back(EV_EOP);
    bit1(1'b1, 1'b1, 1'b1);
    check("fs_pkt_active_after_eop", {31'd0, pkt_active}, 32'd0);

    // short SYNC: 000 1 -> sync_err
    zeros1(3);
    exp_q.push_back(EV_SERR);
    bit1(1'b1, 1'b1, 1'b1);
    bit1(1'b1, 1'b1, 1'b1);
`ifdef SYNC_ERR_CNT_EN
    check("fs_err_cnt_1", {24'd0, err_cnt}, 32'd1);
`endif

    // one SE0 bit only -> eop_err
    sync1();
    data1(1'b0);
    bit1(1'b1, 1'b0, 1'b0);
    exp_q.push_back(EV_EERR);
    bit1(1'b1, 1'b1, 1'b1);
    check("fs_state_hunt_after_eop_err", {30'd0, state_dbg}, 32'd0);

    // bit_en low freezes the FSM; se0 still follows diff
    zeros1(3);
    bit1(1'b0, 1'b1, 1'b1);
    bit1(1'b0, 1'b0, 1'b0);
    bit1(1'b0, 1'b1, 1'b1);
    zeros1(4);
    exp_q.push_back(EV_SYN);
    bit1(1'b1, 1'b1, 1'b1);
    data1(1'b1);
    bit1(1'b0, 1'b0, 1'b0);
    check("fs_state_active_gated", {30'd0, state_dbg}, 32'd1);
    for (int i = 0; i < 3; i++) bit1(1'b1, 1'b0, 1'b0);
    exp_q.push_back(EV_EOP);
    bit1(1'b1, 1'b1, 1'b1);

    // zero counter saturates: 10 zeros then 1 is still a SYNC
    zeros1(10);
    exp_q.push_back(EV_SYN);
    bit1(1'b1, 1'b1, 1'b1);
    bit1(1'b1, 1'b0, 1'b0);
    bit1(1'b1, 1'b0, 1'b0);
    exp_q.push_back(EV_EOP);
    bit1(1'b1, 1'b1, 1'b1);

    // SE0 in HUNT clears the zero run: 5 zeros, SE0, 1 zero, 1 -> sync_err
    zeros1(5);
    bit1(1'b1, 1'b0, 1'b0);
    zeros1(1);
    exp_q.push_back(EV_SERR);
    bit1(1'b1, 1'b1, 1'b1);
    bit1(1'b1, 1'b1, 1'b1);
`ifdef SYNC_ERR_CNT_EN
    check("fs_err_cnt_3", {24'd0, err_cnt}, 32'd3);
`endif

    // asynchronous reset mid-payload, held across active bit_en edges
    sync1();
    data1(1'b1); data1(1'b0);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    bit_en = 1'b1; in_data = 1'b1; diff = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_hold");
    reset = 1'b0;
    sync1();
    data1(1'b1);
    bit1(1'b1, 1'b0, 1'b0);
    bit1(1'b1, 1'b0, 1'b0);
    exp_q.push_back(EV_EOP);
    bit1(1'b1, 1'b1, 1'b1);

    // high-speed instance: 12 zeros -> SYNC, 10 zeros -> sync_err, 11 zeros -> SYNC
    zeros2(12);
    exp_q2.push_back(EV_SYN);
    bit2(1'b1, 1'b1);
    bit2(1'b0, 1'b0);
    bit2(1'b0, 1'b0);
    exp_q2.push_back(EV_EOP);
    bit2(1'b1, 1'b1);
    zeros2(10);
    exp_q2.push_back(EV_SERR);
    bit2(1'b1, 1'b1);
    zeros2(11);
    exp_q2.push_back(EV_SYN);
    bit2(1'b1, 1'b1);
    bit2(1'b0, 1'b0);
    exp_q2.push_back(EV_EERR);
    bit2(1'b1, 1'b1);

    for (int i = 0; i < 4; i++) bit2(1'b1, 1'b1);
    check("fs_queue_drained", exp_q.size(), 32'd0);
    check("hs_queue_drained", exp_q2.size(), 32'd0);
`ifdef SYNC_ERR_CNT_EN
    check("fs_err_cnt_end", {24'd0, err_cnt}, 32'd0);
    check("hs_err_cnt_end", {24'd0, err_cnt_2}, 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_eop_detector.md
SYNC_EOP_DETECTOR -- requirements
Module: sync_eop_detector

Interface
REQ-001 SHALL have parameter SYNC_LEN, default 8: SYNC field length in bits (8 full-speed, 32 high-speed).
REQ-002 SHALL have parameter MIN_SYNC_ZEROS, default SYNC_LEN-1: minimum decoded zeros that must precede the closing 1 of SYNC.
REQ-003 SHALL have parameter EOP_SE0_BITS, default 2: minimum SE0 bit-times for a valid EOP.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_data  input  1  NRZI-decoded receive bit (1 = J/no transition).
REQ-007 diff  input  1  differential-valid; 0 = SE0 on the bus.
REQ-008 bit_en  input  1  bit-time strobe; in_data/diff are consumed only when high.
REQ-009 syn_out  output  1  one-cycle pulse on SYNC recognition.
REQ-010 se0  output  1  registered copy of ~diff, updated every clk.
REQ-011 pkt_active  output  1  high from SYNC acceptance until EOP or abort.
REQ-012 data_out, data_valid  output  1 each  payload bit and its one-cycle qualifier.
REQ-013 eop  output  1  one-cycle pulse on valid EOP.
REQ-014 sync_err, eop_err  output  1 each  one-cycle error pulses.

Function
REQ-015 SHALL implement states HUNT, ACTIVE, EOP_SE0; no transition or counter change when bit_en=0 (se0 excepted).
REQ-016 HUNT: bit_en & diff & ~in_data SHALL increment zero_cnt, saturating at SYNC_LEN-1.
REQ-017 HUNT: bit_en & diff & in_data with zero_cnt>=MIN_SYNC_ZEROS SHALL pulse syn_out, set pkt_active, clear zero_cnt, go ACTIVE, all on the same edge.
REQ-018 HUNT: bit_en & diff & in_data with 1<=zero_cnt<MIN_SYNC_ZEROS SHALL pulse sync_err and clear zero_cnt; with zero_cnt=0 SHALL only hold (idle J).
REQ-019 HUNT: bit_en & ~diff SHALL clear zero_cnt without error.
REQ-020 ACTIVE: bit_en & diff SHALL register data_out=in_data and pulse data_valid; SYNC bits SHALL never produce data_valid.
REQ-021 ACTIVE: bit_en & ~diff SHALL set se0_cnt=1 and go EOP_SE0; no data_valid.
REQ-022 EOP_SE0: bit_en & ~diff SHALL increment se0_cnt, saturating at EOP_SE0_BITS.
REQ-023 EOP_SE0: bit_en & diff with se0_cnt>=EOP_SE0_BITS SHALL pulse eop, clear pkt_active, go HUNT.
REQ-024 EOP_SE0: bit_en & diff with se0_cnt<EOP_SE0_BITS SHALL pulse eop_err, clear pkt_active, go HUNT.
REQ-025 All outputs SHALL be registered; pulse latency one clk after the bit_en edge sampling the deciding bit.
REQ-026 Counter widths SHALL be $clog2 of their saturation value +1; no wrap-around.

Reset
REQ-027 reset SHALL asynchronously force HUNT, zero_cnt=0, se0_cnt=0, all outputs 0.
REQ-028 reset mid-packet SHALL drop the packet with no eop, eop_err or data_valid; reset dominates simultaneous bit_en.
REQ-029 First SYNC after reset release SHALL be recognised normally.

Configuration
REQ-030 With SYNC_ERR_CNT_EN defined: output err_cnt[7:0], incremented on each sync_err or eop_err pulse, saturating at 255, cleared by reset; simultaneous errors count once.
REQ-031 Without SYNC_ERR_CNT_EN: err_cnt port and logic SHALL be absent; all other behaviour identical.

Verification (SYNC_LEN=8, MIN_SYNC_ZEROS=7, EOP_SE0_BITS=2, bit_en every cycle)
REQ-032 Idle 1s, then 0000000 1 -> syn_out pulse one clk after the 1; pkt_active=1; no data_valid for SYNC bits.
REQ-033 SYNC then payload 1011, then diff=0 two bits, then diff=1 in_data=1 -> data_valid x4 with data_out 1,0,1,1; eop pulse; pkt_active=0.
REQ-034 000 1 in HUNT -> sync_err pulse, zero_cnt cleared; err_cnt=1 if SYNC_ERR_CNT_EN.
REQ-035 In ACTIVE, diff=0 one bit then diff=1 -> eop_err pulse, return to HUNT, no eop.
REQ-036 reset asserted mid-payload -> all outputs 0 immediately (asynchronous); fresh SYNC after release -> syn_out.
REQ-037 SYNC_LEN=32, MIN_SYNC_ZEROS=11: 12 zeros then 1 -> syn_out; 10 zeros then 1 -> sync_err.
